// File: rtl/ac97_link_ctrl.sv
// AC'97 link controller: frames commands and DAC samples onto SDATA_OUT, parses SDATA_IN frames.
// Define AC97_LOOPBACK_EN to add a `loopback` input that feeds SDATA_OUT back into the capture path.
module ac97_link_ctrl #(
  parameter int CHANNELS      = 2,
  parameter int SAMPLE_W      = 20,
  parameter int RSTLOW_CYCLES = 150
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         BIT_CLK,
  input  logic                         SDATA_IN,
`ifdef AC97_LOOPBACK_EN
  input  logic                         loopback,
`endif
  output logic                         SDATA_OUT,
  output logic                         SYNC,
  output logic                         RESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_addr,
  input  logic [15:0]                  cmd_data,
  input  logic [CHANNELS*SAMPLE_W-1:0] dac_data,
  input  logic                         dac_valid,
  output logic                         dac_ready,
  output logic [CHANNELS*SAMPLE_W-1:0] adc_data,
  output logic [CHANNELS-1:0]          adc_slot_valid,
  output logic                         adc_valid,
  output logic                         rd_valid,
  output logic [6:0]                   rd_addr,
  output logic [15:0]                  rd_data,
  output logic                         codec_ready,
  output logic                         frame_done,
  output logic                         underrun
);
  localparam int DW  = CHANNELS * SAMPLE_W;
  localparam int RCW = $clog2(RSTLOW_CYCLES + 1);

  logic [2:0]     bclk_q, bclk_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           codec_rst_q, codec_rst_d;
  logic [8:0]     k_q, k_d;
  logic           started_q, started_d;
  logic           sync_q, sync_d;
  logic           sdata_out_q, sdata_out_d;
  logic [254:0]   tx_shift_q, tx_shift_d;
  logic [254:0]   rx_shift_q, rx_shift_d;
  logic           cmd_pend_q, cmd_pend_d;
  logic [7:0]     cmd_addr_q, cmd_addr_d;
  logic [15:0]    cmd_data_q, cmd_data_d;
  logic           dac_full_q, dac_full_d;
  logic [DW-1:0]  dac_q, dac_d;
  logic           underrun_q, underrun_d;
  logic           frame_done_q, frame_done_d;
  logic           codec_ready_q, codec_ready_d;
  logic [DW-1:0]  adc_data_q, adc_data_d;
  logic [CHANNELS-1:0] adc_sv_q, adc_sv_d;
  logic           adc_valid_q, adc_valid_d;
  logic           rd_valid_q, rd_valid_d;
  logic [6:0]     rd_addr_q, rd_addr_d;
  logic [15:0]    rd_data_q, rd_data_d;

  logic           bit_rise, bit_fall, latch, capture, cap_bit;
  logic           cmd_ready_w, dac_ready_w;
  logic [15:0]    tx_tag;
  logic [255:0]   tx_frame;

  assign bit_rise    = bclk_q[1] & ~bclk_q[2];
  assign bit_fall    = ~bclk_q[1] & bclk_q[2];
  assign latch       = codec_rst_q & bit_rise & (k_q == 9'd0);
  assign capture     = codec_rst_q & started_q & bit_fall;
  assign cmd_ready_w = codec_rst_q & ~cmd_pend_q;
  assign dac_ready_w = codec_rst_q & ~dac_full_q;

`ifdef AC97_LOOPBACK_EN
  assign cap_bit = loopback ? sdata_out_q : SDATA_IN;
`else
  assign cap_bit = SDATA_IN;
`endif

  // Outgoing frame image; tx_frame[255] is the bit sent at k=0.
  always_comb begin
    tx_tag     = '0;
    tx_tag[14] = cmd_pend_q;
    tx_tag[13] = cmd_pend_q & ~cmd_addr_q[7];
    for (int c = 0; c < CHANNELS; c++) tx_tag[12-c] = dac_full_q;
    tx_tag[15] = |tx_tag[14:0];
    tx_frame          = '0;
    tx_frame[255:240] = tx_tag;
    if (cmd_pend_q) tx_frame[239:220] = {cmd_addr_q, 12'h000};
    if (cmd_pend_q && !cmd_addr_q[7]) tx_frame[219:200] = {cmd_data_q, 4'h0};
    if (dac_full_q)
      for (int c = 0; c < CHANNELS; c++)
        tx_frame[199-20*c -: SAMPLE_W] = dac_q[c*SAMPLE_W +: SAMPLE_W];
  end

  always_comb begin
    bclk_d        = {bclk_q[1:0], BIT_CLK};
    rst_cnt_d     = rst_cnt_q;
    codec_rst_d   = codec_rst_q;
    k_d           = k_q;
    started_d     = started_q;
    sync_d        = sync_q;
    sdata_out_d   = sdata_out_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    cmd_pend_d    = cmd_pend_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    dac_full_d    = dac_full_q;
    dac_d         = dac_q;
    underrun_d    = underrun_q;
    frame_done_d  = 1'b0;
    codec_ready_d = codec_ready_q;
    adc_data_d    = adc_data_q;
    adc_sv_d      = adc_sv_q;
    adc_valid_d   = 1'b0;
    rd_valid_d    = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;

    if (!codec_rst_q) begin
      if (rst_cnt_q == RCW'(RSTLOW_CYCLES - 1)) codec_rst_d = 1'b1;
      else rst_cnt_d = rst_cnt_q + RCW'(1);
    end

    if (codec_rst_q && bit_rise) begin
      k_d    = (k_q == 9'd255) ? 9'd0 : k_q + 9'd1;
      sync_d = (k_q < 9'd16);
      if (latch) begin
        sdata_out_d = tx_frame[255];
        tx_shift_d  = tx_frame[254:0];
      end else begin
        sdata_out_d = tx_shift_q[254];
        tx_shift_d  = {tx_shift_q[253:0], 1'b0};
      end
    end

    if (latch) begin
      started_d    = 1'b1;
      frame_done_d = 1'b1;
      cmd_pend_d   = 1'b0;
      dac_full_d   = 1'b0;
      if (!dac_full_q) underrun_d = 1'b1;
    end

    // Acceptance is evaluated after the latch so a same-cycle accept waits for the next frame.
    if (cmd_valid && cmd_ready_w) begin
      cmd_pend_d = 1'b1;
      cmd_addr_d = cmd_addr;
      cmd_data_d = cmd_data;
    end
    if (dac_valid && dac_ready_w) begin
      dac_full_d = 1'b1;
      dac_d      = dac_data;
    end

    if (capture) begin
      rx_shift_d = {rx_shift_q[253:0], cap_bit};
      // k=0 means this fall stores index 255; frame bit p currently sits at rx_shift_q[p-1].
      if (k_q == 9'd0) begin
        codec_ready_d = rx_shift_q[254];
        adc_valid_d   = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          adc_sv_d[c] = rx_shift_q[251-c];
          adc_data_d[c*SAMPLE_W +: SAMPLE_W] = rx_shift_q[198-20*c -: SAMPLE_W];
        end
        if (rx_shift_q[253] && rx_shift_q[252]) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = rx_shift_q[237:231];
          rd_data_d  = rx_shift_q[218:203];
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      bclk_q        <= '0;
      rst_cnt_q     <= '0;
      codec_rst_q   <= 1'b0;
      k_q           <= '0;
      started_q     <= 1'b0;
      sync_q        <= 1'b0;
      sdata_out_q   <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      cmd_pend_q    <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      dac_full_q    <= 1'b0;
      dac_q         <= '0;
      underrun_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      codec_ready_q <= 1'b0;
      adc_data_q    <= '0;
      adc_sv_q      <= '0;
      adc_valid_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
    end else begin
      bclk_q        <= bclk_d;
      rst_cnt_q     <= rst_cnt_d;
      codec_rst_q   <= codec_rst_d;
      k_q           <= k_d;
      started_q     <= started_d;
      sync_q        <= sync_d;
      sdata_out_q   <= sdata_out_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      cmd_pend_q    <= cmd_pend_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      dac_full_q    <= dac_full_d;
      dac_q         <= dac_d;
      underrun_q    <= underrun_d;
      frame_done_q  <= frame_done_d;
      codec_ready_q <= codec_ready_d;
      adc_data_q    <= adc_data_d;
      adc_sv_q      <= adc_sv_d;
      adc_valid_q   <= adc_valid_d;
      rd_valid_q    <= rd_valid_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign SDATA_OUT      = sdata_out_q;
  assign SYNC           = sync_q;
  assign RESET          = codec_rst_q;
  assign cmd_ready      = cmd_ready_w;
  assign dac_ready      = dac_ready_w;
  assign adc_data       = adc_data_q;
  assign adc_slot_valid = adc_sv_q;
  assign adc_valid      = adc_valid_q;
  assign rd_valid       = rd_valid_q;
  assign rd_addr        = rd_addr_q;
  assign rd_data        = rd_data_q;
  assign codec_ready    = codec_ready_q;
  assign frame_done     = frame_done_q;
  assign underrun       = underrun_q;
endmodule

// File: tb/tb_ac97_link_ctrl.sv
// Directed bench for ac97_link_ctrl: codec model captures SDATA_OUT frames and drives SDATA_IN frames.
`timescale 1ns/1ps
module tb_ac97_link_ctrl;
  localparam int CH = 2;
  localparam int SW = 16;

  logic sys_clk = 1'b0, rst = 1'b0, BIT_CLK = 1'b0, SDATA_IN = 1'b0;
  logic SDATA_OUT, SYNC, RESET;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic [CH*SW-1:0] dac_data = '0;
  logic dac_valid = 1'b0, dac_ready;
  logic [CH*SW-1:0] adc_data;
  logic [CH-1:0] adc_slot_valid;
  logic adc_valid, rd_valid, codec_ready, frame_done, underrun;
  logic [6:0] rd_addr;
  logic [15:0] rd_data;
`ifdef AC97_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  ac97_link_ctrl #(.CHANNELS(CH), .SAMPLE_W(SW), .RSTLOW_CYCLES(150)) dut (
    .sys_clk(sys_clk), .rst(rst), .BIT_CLK(BIT_CLK), .SDATA_IN(SDATA_IN),
`ifdef AC97_LOOPBACK_EN
    .loopback(loopback),
`endif
    .SDATA_OUT(SDATA_OUT), .SYNC(SYNC), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .adc_data(adc_data), .adc_slot_valid(adc_slot_valid), .adc_valid(adc_valid),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .codec_ready(codec_ready), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 sys_clk = ~sys_clk;
  initial begin
    #3;
    forever #40.69 BIT_CLK = ~BIT_CLK;
  end

  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end else
      $display("ok   %s = 0x%0h", tag, got);
  endtask

  // Codec side: frame index tracked from SYNC rising; SDATA_IN changes on BIT_CLK falls.
  localparam logic [255:0] FRAME_A = {16'hE000, 20'h26000, 20'h000F0, 200'h0};
  localparam logic [255:0] FRAME_B = {16'h9800, 20'h0, 20'h0, 20'hC3C3F, 20'h7E817, 160'h0};
  localparam logic [255:0] FRAME_C = {16'h1000, 20'h0, 20'h0, 20'h5A5A5, 20'hFFFFF, 160'h0};
  logic [255:0] codec_frame = FRAME_A;
  logic [255:0] cur_frame = '0;
  logic [255:0] tx_frames [0:15];
  int tx_sync [0:15];
  int tx_count = 0, mon_k = 0, sync_cnt = 0;
  bit mon_on = 0, sync_prev = 0;

  always @(negedge BIT_CLK) begin
    if (SYNC && !sync_prev) begin
      mon_k = 0; mon_on = 1; sync_cnt = 0;
    end else if (mon_on)
      mon_k = (mon_k + 1) % 256;
    if (mon_on) begin
      cur_frame[255-mon_k] = SDATA_OUT;
      if (SYNC) sync_cnt++;
      SDATA_IN = codec_frame[255-mon_k];
      if (mon_k == 255 && tx_count < 16) begin
        tx_frames[tx_count] = cur_frame;
        tx_sync[tx_count] = sync_cnt;
        $display("frame %0d out: tag=%h slot1=%h slot2=%h slot3=%h slot4=%h", tx_count,
                 cur_frame[255:240], cur_frame[239:220], cur_frame[219:200],
                 cur_frame[199:180], cur_frame[179:160]);
        tx_count++;
      end
    end
    sync_prev = SYNC;
  end

  int adc_count = 0, rd_count = 0, pulse_count = 0;
  logic [CH*SW-1:0] last_adc = '0;
  logic [CH-1:0] last_sv = '0;
  logic last_cr = 1'b0;
  logic [6:0] last_rd_addr = '0;
  logic [15:0] last_rd_data = '0;
  always @(negedge sys_clk) begin
    if (adc_valid) begin
      adc_count++; last_adc = adc_data; last_sv = adc_slot_valid; last_cr = codec_ready;
      $display("adc %0d: data=%h slot_valid=%b codec_ready=%b", adc_count, adc_data, adc_slot_valid, codec_ready);
    end
    if (rd_valid) begin
      rd_count++; last_rd_addr = rd_addr; last_rd_data = rd_data;
      $display("read %0d: addr=%h data=%h", rd_count, rd_addr, rd_data);
    end
    if (!rst && (adc_valid || rd_valid || frame_done)) pulse_count++;
  end

  int w;
  realtime t_rst_hi, dt;

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_RESET", 32'(RESET), 0);
    check("rst_SYNC", 32'(SYNC), 0);
    check("rst_SDATA_OUT", 32'(SDATA_OUT), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_dac_ready", 32'(dac_ready), 0);
    check("rst_pulses", {29'd0, adc_valid, rd_valid, frame_done}, 0);
    check("rst_codec_ready", 32'(codec_ready), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_adc_data", adc_data, 0);
    check("rst_rd", {9'd0, rd_addr, rd_data}, 0);

    @(negedge sys_clk) rst = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      @(posedge sys_clk);
      #1;
      if (i == 149) begin
        check("RESET_149", 32'(RESET), 0);
        check("ready_while_RESET", {30'd0, cmd_ready, dac_ready}, 0);
        check("SYNC_while_RESET", 32'(SYNC), 0);
      end
    end
    check("RESET_150", 32'(RESET), 1);
    check("ready_after_RESET", {30'd0, cmd_ready, dac_ready}, 3);
    t_rst_hi = $realtime;

    w = 0;
    while (!SYNC && w < 50) begin @(negedge sys_clk); w++; end
    dt = $realtime - t_rst_hi;
    check("first_sync_seen", 32'(SYNC), 1);
    check("first_sync_delay_ok", 32'(dt <= 120.0), 1);
    check("frame_done_at_latch", 32'(frame_done), 1);

    @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_addr = 8'h02; cmd_data = 16'h8000;
    $display("cmd write addr=02 data=8000");
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    check("cmd_ready_busy", 32'(cmd_ready), 0);

    w = 0;
    while (tx_count < 1 && w < 5000) begin @(negedge sys_clk); w++; end
    check("wait_frame0", 32'(tx_count >= 1), 1);
    codec_frame = FRAME_B;
    check("f0_tag", 32'(tx_frames[0][255:240]), 32'h0000);
    check("f0_sync_bits", tx_sync[0], 16);

    w = 0;
    while (rd_count < 1 && w < 500) begin @(negedge sys_clk); w++; end
    check("wait_rd", rd_count, 1);
    check("rd_addr", 32'(last_rd_addr), 32'h26);
    check("rd_data", 32'(last_rd_data), 32'h000F);
    check("codec_ready_A", 32'(last_cr), 1);
    check("adc_sv_A", 32'(last_sv), 0);
    check("underrun_set", 32'(underrun), 1);

    w = 0;
    while (!frame_done && w < 3000) begin @(negedge sys_clk); w++; end
    check("wait_latch1", 32'(frame_done), 1);
    check("cmd_ready_after_latch", 32'(cmd_ready), 1);
    check("dac_ready_idle", 32'(dac_ready), 1);
    @(negedge sys_clk);
    dac_valid = 1'b1; dac_data = {16'h1234, 16'hABCD};
    $display("dac push 1234_ABCD");
    @(negedge sys_clk);
    dac_valid = 1'b0;
    check("dac_ready_busy", 32'(dac_ready), 0);

    w = 0;
    while (tx_count < 2 && w < 5000) begin @(negedge sys_clk); w++; end
    check("wait_frame1", 32'(tx_count >= 2), 1);
    codec_frame = FRAME_C;
    check("f1_tag", 32'(tx_frames[1][255:240]), 32'hE000);
    check("f1_slot1", 32'(tx_frames[1][239:220]), 32'h02000);
    check("f1_slot2", 32'(tx_frames[1][219:200]), 32'h80000);
    check("f1_slot3", 32'(tx_frames[1][199:180]), 32'h0);

    w = 0;
    while (adc_count < 2 && w < 500) begin @(negedge sys_clk); w++; end
    check("wait_adc_B", adc_count, 2);
    check("adc_data_B", last_adc, 32'h7E81C3C3);
    check("adc_sv_B", 32'(last_sv), 3);
    check("codec_ready_B", 32'(last_cr), 1);
    check("no_rd_B", rd_count, 1);

    w = 0;
    while (tx_count < 3 && w < 5000) begin @(negedge sys_clk); w++; end
    check("wait_frame2", 32'(tx_count >= 3), 1);
    check("f2_tag", 32'(tx_frames[2][255:240]), 32'h9800);
    check("f2_slot1", 32'(tx_frames[2][239:220]), 32'h0);
    check("f2_slot3", 32'(tx_frames[2][199:180]), 32'hABCD0);
    check("f2_slot4", 32'(tx_frames[2][179:160]), 32'h12340);

    w = 0;
    while (adc_count < 3 && w < 500) begin @(negedge sys_clk); w++; end
    check("wait_adc_C", adc_count, 3);
    check("adc_data_C", last_adc, 32'hFFFF5A5A);
    check("adc_sv_C", 32'(last_sv), 1);
    check("codec_ready_C", 32'(last_cr), 0);
    check("dac_ready_after_latch", 32'(dac_ready), 1);

`ifdef AC97_LOOPBACK_EN
    loopback = 1'b1;
    w = 0;
    while (!frame_done && w < 3000) begin @(negedge sys_clk); w++; end
    check("wait_latch3", 32'(frame_done), 1);
    @(negedge sys_clk);
    dac_valid = 1'b1; dac_data = {16'h5555, 16'hAAAA};
    $display("dac push 5555_AAAA (loopback)");
    @(negedge sys_clk);
    dac_valid = 1'b0;
    w = 0;
    while (adc_count < 5 && w < 6000) begin @(negedge sys_clk); w++; end
    check("wait_adc_loop", adc_count, 5);
    check("adc_data_loop", last_adc, 32'h5555AAAA);
    check("adc_sv_loop", 32'(last_sv), 3);
`endif

    w = 0;
    while (!SYNC && w < 5000) begin @(negedge sys_clk); w++; end
    check("wait_sync_midframe", 32'(SYNC), 1);
    repeat (20) @(negedge sys_clk);
    #2 rst = 1'b0;
    $display("rst asserted mid-frame");
    #1;
    check("abort_SYNC", 32'(SYNC), 0);
    check("abort_RESET", 32'(RESET), 0);
    check("abort_underrun", 32'(underrun), 0);
    check("abort_codec_ready", 32'(codec_ready), 0);
    check("abort_ready", {30'd0, cmd_ready, dac_ready}, 0);
    check("abort_adc_data", adc_data, 0);
    check("abort_rd", {9'd0, rd_addr, rd_data}, 0);
    repeat (300) @(negedge sys_clk);
    check("abort_no_pulses", pulse_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ac97_link_ctrl.md
AC97_LINK_CTRL -- requirements
Module: ac97_link_ctrl

Interface
REQ-001 Parameter CHANNELS, default 2, number of PCM slots used (1..9), mapped to AC-link slots 3..(2+CHANNELS).
REQ-002 Parameter SAMPLE_W, default 20, PCM sample width (16..20).
REQ-003 Parameter RSTLOW_CYCLES, default 150, sys_clk cycles codec RESET held low.
REQ-004 sys_clk  in  1  sole clock, 100 MHz max.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 BIT_CLK  in  1  codec bit clock, asynchronous, sampled in sys_clk domain.
REQ-007 SDATA_IN  in  1  codec serial input.
REQ-008 SDATA_OUT, SYNC, RESET  out  1 each  codec serial data, frame sync, codec reset (active-low).
REQ-009 cmd_valid / cmd_ready  in / out  1 each  command handshake.
REQ-010 cmd_addr  in  8  bit7=1 read, bits6:0 register index; cmd_data  in  16  write data.
REQ-011 dac_data  in  CHANNELS*SAMPLE_W  packed samples, channel 0 in LSBs; dac_valid / dac_ready  in / out  1 each.
REQ-012 adc_data  out  CHANNELS*SAMPLE_W; adc_slot_valid  out  CHANNELS; adc_valid  out  1 (1-cycle pulse).
REQ-013 rd_valid  out  1 pulse; rd_addr  out  7; rd_data  out  16.
REQ-014 codec_ready, frame_done, underrun  out  1 each.

Function
REQ-015 BIT_CLK passes a 2-flop synchronizer; bit_rise / bit_fall are single-cycle sys_clk pulses from synchronized edges.
REQ-016 9-bit bit counter k, 0..255, wraps 255->0; advances only on bit_rise; stopped BIT_CLK freezes counter and outputs.
REQ-017 On bit_rise, SDATA_OUT drives bit k of the outgoing frame, then k increments; SYNC=1 while driving k=0..15, else 0.
REQ-018 Slot n (1..12) occupies k=16+20(n-1)..35+20(n-1), MSB first; samples left-justified in 20 bits, LSBs zero.
REQ-019 Frame latch on bit_rise with k=0: pending command and DAC holding register copied to shift registers; frame_done pulses 1 cycle.
REQ-020 Tag: bit0 = OR of bits1..(2+CHANNELS); bit1 = command present; bit2 = command present and write; bits 3.. = DAC sample present per channel; rest 0.
REQ-021 Slot1 = {cmd_addr, 12'h000}; slot2 = {cmd_data, 4'h0} for write, zero for read.
REQ-022 cmd_ready=1 when no command pending; accepted on cmd_valid&cmd_ready; pending clears at frame latch; new acceptance earliest 1 cycle after latch.
REQ-023 dac_ready=1 when DAC holding register empty; accepted on dac_valid&dac_ready; empty at frame latch -> channel tag bits 0, slots zero, underrun sticky set.
REQ-024 Simultaneous accept and frame latch same cycle: accept lands in holding register for the following frame; no data lost.
REQ-025 On bit_fall, SDATA_IN stored at index = k of most recent bit_rise minus 1 (mod 256).
REQ-026 After capturing index 255: codec_ready = tag bit15; adc_data, adc_slot_valid (tag bits 12..(13-CHANNELS)) updated, adc_valid pulses 1 cycle.
REQ-027 Same point: if tag bits14 and 13 both 1, rd_valid pulses, rd_addr = slot1[18:12], rd_data = slot2[19:4].
REQ-028 ADC slot contents returned as upper SAMPLE_W bits of each 20-bit slot.

Reset
REQ-029 rst low: k=0, SYNC=0, SDATA_OUT=0, RESET=0, cmd_ready=0, dac_ready=0, all pulses 0, adc_data/rd_data/rd_addr=0, codec_ready=0, underrun=0, holding registers empty.
REQ-030 After rst release, RESET stays 0 for RSTLOW_CYCLES sys_clk cycles, then 1 permanently until next rst.
REQ-031 While RESET=0, link engine idle (k=0, SYNC=0, ready outputs 0); first frame starts on first bit_rise after RESET=1.
REQ-032 rst asserted mid-frame aborts frame immediately; no partial pulses.

Configuration
REQ-033 Macro AC97_LOOPBACK_EN defined: extra input port loopback (1 bit); loopback=1 routes internal SDATA_OUT into the capture path instead of SDATA_IN.
REQ-034 Macro undefined: no loopback port; capture always from SDATA_IN.

Verification
REQ-035 rst pulse, BIT_CLK 12.288 MHz -> RESET high exactly 150 cycles after release; first SYNC rises on next bit_rise, high 16 bit clocks.
REQ-036 Write cmd_addr=8'h02, cmd_data=16'h8000 -> tag 16'hE000 (CHANNELS=2, no DAC), slot1=20'h02000, slot2=20'h80000; cmd_ready returns 1 after frame latch.
REQ-037 Codec model returns tag 16'hE000, slot1=20'h26000, slot2=20'h000F0 -> rd_valid pulse, rd_addr=7'h26, rd_data=16'h000F, codec_ready=1.
REQ-038 CHANNELS=2, SAMPLE_W=16, dac_data={16'h1234,16'hABCD} -> slot3=20'hABCD0, slot4=20'h12340, tag bits3,4=1.
REQ-039 No dac_valid for one frame -> tag bits3,4=0, slots zero, underrun=1 until rst.
REQ-040 With AC97_LOOPBACK_EN, loopback=1, DAC {16'h5555,16'hAAAA} -> next adc_valid with adc_data={16'h5555,16'hAAAA}, adc_slot_valid=2'b11.
